uart_frame_sched: RTL and testbench
===================================

UART_FRAME_SCHED -- requirements
Module: uart_frame_sched

Interface
Parameters (name, default, meaning):
REQ-001 HEADER, 8'hAA, first byte of every frame.
REQ-002 CMD0, 8'h01, command byte for channel 0 (alarm).
REQ-003 CMD1, 8'h02, command byte for channel 1 (save key).
REQ-004 CMD2, 8'h03, command byte for channel 2 (fetch key).
REQ-005 CMD3, 8'h04, command byte for channel 3 (voice).
REQ-006 TIMEOUT_CYC, 16'd60000, maximum number of WAIT cycles allowed per byte before the frame is aborted.

Ports (name, direction, width, meaning):
REQ-007 clk  in  1  system clock; the block has one clock; reset is synchronous and active-high.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 req  in  4  per-channel request strobes, one cycle each; bit 0 is alarm, bit 3 is voice.
REQ-010 param_bus  in  32  per-channel parameter byte; channel k uses bits [8k+7:8k], sampled in any cycle where req[k]=1.
REQ-011 tx_down  in  1  byte-transmitter done pulse, one cycle.
REQ-012 date_byte  out  8  byte presented to the byte transmitter.
REQ-013 send_en  out  1  one-cycle start pulse to the byte transmitter.
REQ-014 grant  out  4  one-hot channel currently being sent; 0 when idle.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one-cycle pulse when all four bytes of a frame are acknowledged.
REQ-017 timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout.

Function
REQ-018 Request capture:
- req[k]=1 sets pend[k] and loads par[k] from param_bus.
- A repeat request while pend[k] is already set overwrites par[k]; only one frame is sent (latest parameter wins).
REQ-019 Frame format, bytes sent in order:
- idx0: HEADER
- idx1: CMDk
- idx2: par[k]
- idx3: checksum = (HEADER + CMDk + par[k]) mod 256, computed with 8-bit wrap.
REQ-020 Arbitration is fixed priority, lowest set pend index wins; it is evaluated only in IDLE.
REQ-021 FSM states: IDLE, GRANT, SEND, WAIT, DONE.
REQ-022 IDLE: if any pend bit is set, go to GRANT on the next edge; otherwise stay in IDLE.
REQ-023 GRANT (one cycle):
- latch the winning channel into grant, and latch its CMD, parameter and checksum into a frame buffer;
- clear pend of the winner;
- set idx=0;
- go to SEND.
REQ-024 If req[k] arrives for the winner in the GRANT cycle:
- pend[k] stays set and par[k] updates;
- the current frame uses the previously latched parameter.
REQ-025 SEND (one cycle):
- send_en=1 and date_byte=frame[idx];
- clear the timeout counter;
- go to WAIT.
REQ-026 WAIT:
- date_byte holds frame[idx] and send_en=0;
- the timeout counter increments each cycle.
REQ-027 WAIT exits:
- tx_down=1 with idx<3: idx++ and go to SEND, giving a 1-cycle gap between tx_down and the next send_en;
- tx_down=1 with idx=3: go to DONE.
REQ-028 DONE (one cycle): frame_done=1, grant clears to 0, go to IDLE.
REQ-029 Timeout: if the counter reaches TIMEOUT_CYC-1 in WAIT without tx_down:
- timeout_err=1 for one cycle;
- grant clears and the FSM goes to IDLE;
- the aborted frame is not retried.
REQ-030 If tx_down and the timeout limit occur in the same cycle, tx_down wins and no error is raised.
REQ-031 tx_down is ignored in IDLE, GRANT, SEND and DONE.
REQ-032 Requests from any channel, including the granted one, are captured in every state; they never disturb the frame in progress.
REQ-033 Worst-case latency from req to first send_en is 3 cycles when idle: capture, GRANT, SEND.

Reset
REQ-034 Synchronous rst=1 drives the following on the next edge, from any state including mid-frame:
- FSM to IDLE; pend=0; par=0; idx=0; timeout counter=0;
- outputs date_byte=0, send_en=0, grant=0, busy=0, frame_done=0, timeout_err=0.
REQ-035 A req asserted in the same cycle as rst is discarded.
REQ-036 A tx_down arriving after a reset is ignored.

Verification
REQ-037 Single frame:
- stimulus: req=4'b0010 with param_bus[15:8]=8'h05; tx_down returned 10 cycles after each send_en;
- response: bytes AA,02,05,B1; grant=0010 throughout; frame_done once; first send_en 3 cycles after req.
REQ-038 Priority:
- stimulus: req=4'b1001 in one cycle;
- response: channel 0 frame first, then channel 3 frame; exactly 8 send_en pulses.
REQ-039 Checksum wrap:
- stimulus: CMD3 parameter 8'hFF, req[3];
- response: checksum byte = (AA+04+FF) mod 256 = 8'hAD.
REQ-040 Timeout:
- stimulus: TIMEOUT_CYC=16; tx_down withheld after the second send_en;
- response: timeout_err pulse 16 cycles after that send_en, return to IDLE, no frame_done; a later request is served normally.
REQ-041 Mid-frame reset:
- stimulus: rst=1 for one cycle during WAIT of idx2, with pend[1] set;
- response: all outputs and pend are 0 next cycle, and no further send_en occurs.
REQ-042 Re-request during grant:
- stimulus: req[2] with param 8'h11, then req[2] with param 8'h22 in the GRANT cycle;
- response: the first frame carries 11 and a second frame carries 22.

Source files
------------

// File: rtl/uart_frame_sched.sv
// Four-channel UART frame scheduler: captures per-channel requests, arbitrates by fixed
// priority and streams HEADER/CMD/PARAM/CHECKSUM frames to a byte transmitter.

module uart_frame_chan (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] param,
  input  logic       clr,
  output logic       pend,
  output logic [7:0] par
);
  // A request landing in the same cycle as the grant clear keeps the channel pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      par  <= '0;
    end else if (req) begin
      pend <= 1'b1;
      par  <= param;
    end else if (clr) begin
      pend <= 1'b0;
    end
  end
endmodule

module uart_frame_sched #(
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter logic [7:0]  CMD0        = 8'h01,
  parameter logic [7:0]  CMD1        = 8'h02,
  parameter logic [7:0]  CMD2        = 8'h03,
  parameter logic [7:0]  CMD3        = 8'h04,
  parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] param_bus,
  input  logic        tx_down,
  output logic [7:0]  date_byte,
  output logic        send_en,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, DONE} state_t;

  state_t                             state, state_n;
  logic [NUM_LANES-1:0]               pend, clr, win_oh;
  logic [NUM_LANES-1:0][VEC_W-1:0]    par;
  logic [3:0][VEC_W-1:0]              frame;
  logic [1:0]                         idx;
  logic [15:0]                        cnt;
  logic [VEC_W-1:0]                   cmd_sel, par_sel, csum;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_chan
    uart_frame_chan u_chan (
      .clk   (clk),
      .rst   (rst),
      .req   (req[g]),
      .param (param_bus[VEC_W*g +: VEC_W]),
      .clr   (clr[g]),
      .pend  (pend[g]),
      .par   (par[g])
    );
  end

  assign win_oh = pend & (~pend + 4'd1);

  always_comb begin
    cmd_sel = '0;
    par_sel = '0;
    unique case (1'b1)
      grant[0]: cmd_sel = CMD0;
      grant[1]: cmd_sel = CMD1;
      grant[2]: cmd_sel = CMD2;
      grant[3]: cmd_sel = CMD3;
      default:  cmd_sel = '0;
    endcase
    for (int i = 0; i < NUM_LANES; i++)
      par_sel = par_sel | (par[i] & {VEC_W{grant[i]}});
    csum = HEADER + cmd_sel + par_sel;
  end

  always_comb begin
    state_n     = state;
    send_en     = 1'b0;
    frame_done  = 1'b0;
    timeout_err = 1'b0;
    clr         = '0;
    case (state)
      IDLE:  if (|pend) state_n = GRANT;
      GRANT: begin
        clr     = grant;
        state_n = SEND;
      end
      SEND: begin
        send_en = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        // tx_down takes precedence over a simultaneous timeout
        if (tx_down) state_n = (idx == 2'd3) ? DONE : SEND;
        else if (cnt == TIMEOUT_CYC - 16'd1) begin
          timeout_err = 1'b1;
          state_n     = IDLE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign date_byte = (state == SEND || state == WAIT) ? frame[idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      idx   <= '0;
      cnt   <= '0;
      frame <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (|pend) grant <= win_oh;
        GRANT: begin
          frame <= {csum, par_sel, cmd_sel, HEADER};
          idx   <= '0;
        end
        SEND: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (tx_down && idx != 2'd3) idx <= idx + 2'd1;
        end
        default: ;
      endcase
      if (state_n == IDLE) grant <= '0;
    end
  end
endmodule

// File: tb/tb_uart_frame_sched.sv
// Scoreboard bench for uart_frame_sched: stimulus pushes expected bytes/events,
// a negedge monitor pops and compares whenever the DUT presents send_en/frame_done/timeout_err.

module tb_uart_frame_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] param_bus = '0;
  logic        tx_down = 1'b0;
  logic [7:0]  date_byte;
  logic        send_en, busy, frame_done, timeout_err;
  logic [3:0]  grant;

  uart_frame_sched #(.TIMEOUT_CYC(16'd16)) dut (
    .clk(clk), .rst(rst), .req(req), .param_bus(param_bus), .tx_down(tx_down),
    .date_byte(date_byte), .send_en(send_en), .grant(grant), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_SEND = 2'd0, K_DONE = 2'd1, K_TO = 2'd2;
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] gnt;
    logic [7:0] b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, last_send_cyc = 0;
  int   rsp_cnt = 0, drop_at = -1, cd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0] g, input logic [7:0] cmd,
                            input logic [7:0] p, input logic [7:0] cs);
    q.push_back('{K_SEND, g, 8'hAA});
    q.push_back('{K_SEND, g, cmd});
    q.push_back('{K_SEND, g, p});
    q.push_back('{K_SEND, g, cs});
    q.push_back('{K_DONE, 4'd0, 8'd0});
  endtask

  task automatic do_req(input logic [3:0] m, input logic [31:0] pb);
    @(negedge clk);
    req = m; param_bus = pb;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) begin ok = 1'b1; break; end
    end
    chk(name, ok, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: tx_down 10 cycles after each send_en, optionally dropped once.
  initial begin
    forever begin
      @(negedge clk);
      tx_down = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_down = 1'b1;
      end
      if (send_en) begin
        rsp_cnt++;
        if (rsp_cnt != drop_at) cd = 10;
      end
    end
  end

  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (send_en) begin
        chk("send_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("send_kind", send_en ? K_SEND : K_DONE, e.kind);
          chk("send_byte", date_byte, e.b);
          chk("send_grant", grant, e.gnt);
        end
        last_send_cyc = cyc;
      end
      if (frame_done) begin
        chk("done_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("done_kind", K_DONE, e.kind);
        end
      end
      if (timeout_err) begin
        chk("to_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("to_kind", K_TO, e.kind);
        end
        chk("to_latency", cyc - last_send_cyc, 16);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_send_en", send_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 4'd0);
    chk("rst_date_byte", date_byte, 8'd0);
    rst = 1'b0;

    // single frame on channel 1, plus first send_en latency
    push_frame(4'b0010, 8'h02, 8'h05, 8'hB1);
    do_req(4'b0010, 32'h0000_0500);
    repeat (2) @(negedge clk);
    chk("latency_send_en", send_en, 1'b1);
    wait_idle("idle_single");

    // priority: channel 0 then channel 3
    push_frame(4'b0001, 8'h01, 8'h10, 8'hBB);
    push_frame(4'b1000, 8'h04, 8'h20, 8'hCE);
    do_req(4'b1001, 32'h2000_0010);
    wait_idle("idle_priority");

    // checksum wrap
    push_frame(4'b1000, 8'h04, 8'hFF, 8'hAD);
    do_req(4'b1000, 32'hFF00_0000);
    wait_idle("idle_wrap");

    // timeout after the second byte, then a normal frame
    drop_at = rsp_cnt + 2;
    q.push_back('{K_SEND, 4'b0010, 8'hAA});
    q.push_back('{K_SEND, 4'b0010, 8'h02});
    q.push_back('{K_TO, 4'd0, 8'd0});
    do_req(4'b0010, 32'h0000_3300);
    wait_idle("idle_timeout");
    push_frame(4'b0001, 8'h01, 8'h7F, 8'h2A);
    do_req(4'b0001, 32'h0000_007F);
    wait_idle("idle_after_timeout");

    // re-request during GRANT: first frame 11, second frame 22
    push_frame(4'b0100, 8'h03, 8'h11, 8'hBE);
    push_frame(4'b0100, 8'h03, 8'h22, 8'hCF);
    @(negedge clk); req = 4'b0100; param_bus = 32'h0011_0000;
    @(negedge clk); req = '0;
    @(negedge clk); req = 4'b0100; param_bus = 32'h0022_0000;
    @(negedge clk); req = '0;
    wait_idle("idle_rerequest");

    // mid-frame reset during WAIT of idx2 with channel 1 pending
    q.push_back('{K_SEND, 4'b0001, 8'hAA});
    q.push_back('{K_SEND, 4'b0001, 8'h01});
    q.push_back('{K_SEND, 4'b0001, 8'h44});
    do_req(4'b0001, 32'h0000_0044);
    begin
      int n = 0;
      for (int k = 0; k < 100 && n < 3; k++) begin
        @(negedge clk);
        if (send_en) n++;
      end
      chk("reach_idx2", n, 3);
    end
    @(negedge clk); req = 4'b0010; param_bus = 32'h0000_5500;
    @(negedge clk); req = 4'b0100; rst = 1'b1;
    @(negedge clk); req = '0; rst = 1'b0;
    chk("mrst_send_en", send_en, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_grant", grant, 4'd0);
    chk("mrst_date_byte", date_byte, 8'd0);
    chk("mrst_frame_done", frame_done, 1'b0);
    chk("mrst_timeout_err", timeout_err, 1'b0);
    repeat (40) @(negedge clk);
    chk("mrst_stays_idle", busy, 1'b0);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
